// File: rtl/pipe_controller_mc.sv
// Pipelined control unit for the 5-stage CPU with a multi-cycle DIV/MOD sequencer.
// Decodes the D-stage instruction slice and carries control through E/M/W.
// Flags are evaluated in E. DIV/MOD stay in E for DIV_CYCLES cycles while MCBusy stalls F/D/E.
//
// Field map of InstrD (instruction bits [25:14]):
//   [11]    cond  (1 = execute only when Z is set)
//   [10:9]  op
//   [8]     I / immediate operand (data-processing)
//   [7:5]   cmd   (000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101 MOV, 110 EQV)
//   [4]     S for data-processing, L for memory (1 = GET)
//   [3:0]   Rd
module pipe_controller_mc #(
    parameter int          ALUCTRL_W  = 3,
    parameter int          FLAG_W     = 4,
    parameter int          DIV_CYCLES = 8,
    parameter logic [3:0]  PC_IDX     = 4'b1001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [11:0]          InstrD,
    input  logic [FLAG_W-1:0]    ALUFlagsE,
    input  logic                 FlushE,
    output logic [1:0]           RegSrcD,
    output logic [1:0]           ImmSrcD,
    output logic                 ALUSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 BranchTakenE,
    output logic                 MCStartE,
    output logic                 MCBusy,
    output logic                 MemtoRegE,
    output logic                 MemWriteM,
    output logic                 RegWriteM,
    output logic                 MemtoRegW,
    output logic                 RegWriteW,
    output logic                 PCSrcW,
    output logic                 PCWrPendingF
);

    localparam int         Z_IDX   = FLAG_W - 2;
    localparam logic [2:0] CMD_ADD = 3'b000;
    localparam logic [2:0] CMD_SUB = 3'b001;
    localparam logic [2:0] CMD_MUL = 3'b010;
    localparam logic [2:0] CMD_DIV = 3'b011;
    localparam logic [2:0] CMD_MOD = 3'b100;
    localparam logic [2:0] CMD_MOV = 3'b101;
    localparam logic [2:0] CMD_EQV = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mc_state_t;

    // D-stage decode signals
    logic [1:0]           reg_src_d_s;
    logic [1:0]           imm_src_d_s;
    logic                 alu_src_d_s;
    logic                 mem_to_reg_d_s;
    logic                 reg_write_d_s;
    logic                 mem_write_d_s;
    logic                 branch_d_s;
    logic                 alu_op_d_s;
    logic [ALUCTRL_W-1:0] alu_ctrl_d_s;
    logic [1:0]           flag_write_d_s;
    logic                 no_write_d_s;
    logic                 mc_op_d_s;
    logic                 pc_src_d_s;

    // E-stage registers
    logic                 alu_src_e_r;
    logic [ALUCTRL_W-1:0] alu_ctrl_e_r;
    logic                 mem_to_reg_e_r;
    logic                 reg_write_e_r;
    logic                 mem_write_e_r;
    logic                 branch_e_r;
    logic                 pc_src_e_r;
    logic [1:0]           flag_write_e_r;
    logic                 cond_e_r;
    logic                 no_write_e_r;
    logic                 mc_op_e_r;
    logic [FLAG_W-1:0]    flags_e_r;

    // M/W-stage registers
    logic                 mem_to_reg_m_r;
    logic                 reg_write_m_r;
    logic                 mem_write_m_r;
    logic                 pc_src_m_r;
    logic                 mem_to_reg_w_r;
    logic                 reg_write_w_r;
    logic                 pc_src_w_r;

    // Sequencer
    mc_state_t            state_r;
    mc_state_t            state_n_s;
    logic [7:0]           cnt_r;
    logic [7:0]           cnt_n_s;
    logic                 mc_trig_s;
    logic                 mc_start_s;
    logic                 mc_busy_s;

    // E-stage evaluation
    logic                 cond_ex_e_s;
    logic                 commit_e_s;
    logic                 flag_upd_s;
    logic [FLAG_W-1:0]    flag_mask_s;

    // Main decoder: op selects the control word
    always_comb begin
        {reg_src_d_s, imm_src_d_s, alu_src_d_s, mem_to_reg_d_s,
         reg_write_d_s, mem_write_d_s, branch_d_s, alu_op_d_s} = 10'b00_00_0_0_0_0_0_0;
        case (InstrD[10:9])
            2'b00: begin
                if (InstrD[8]) begin
                    {reg_src_d_s, imm_src_d_s, alu_src_d_s, mem_to_reg_d_s,
                     reg_write_d_s, mem_write_d_s, branch_d_s, alu_op_d_s} = 10'b00_00_1_0_1_0_0_1;
                end else begin
                    {reg_src_d_s, imm_src_d_s, alu_src_d_s, mem_to_reg_d_s,
                     reg_write_d_s, mem_write_d_s, branch_d_s, alu_op_d_s} = 10'b00_00_0_0_1_0_0_1;
                end
            end
            2'b10: begin
                if (InstrD[4]) begin
                    {reg_src_d_s, imm_src_d_s, alu_src_d_s, mem_to_reg_d_s,
                     reg_write_d_s, mem_write_d_s, branch_d_s, alu_op_d_s} = 10'b00_01_1_1_1_0_0_0;
                end else begin
                    {reg_src_d_s, imm_src_d_s, alu_src_d_s, mem_to_reg_d_s,
                     reg_write_d_s, mem_write_d_s, branch_d_s, alu_op_d_s} = 10'b10_01_1_1_0_1_0_0;
                end
            end
            2'b01: begin
                {reg_src_d_s, imm_src_d_s, alu_src_d_s, mem_to_reg_d_s,
                 reg_write_d_s, mem_write_d_s, branch_d_s, alu_op_d_s} = 10'b01_10_1_0_0_0_1_0;
            end
            default: begin
                {reg_src_d_s, imm_src_d_s, alu_src_d_s, mem_to_reg_d_s,
                 reg_write_d_s, mem_write_d_s, branch_d_s, alu_op_d_s} = 10'b00_00_0_0_0_0_0_0;
            end
        endcase
    end

    // ALU decoder: operation, flag-write mask, EQV write squash and multi-cycle marker
    always_comb begin
        alu_ctrl_d_s   = ALUCTRL_W'(CMD_ADD);
        flag_write_d_s = 2'b00;
        no_write_d_s   = 1'b0;
        mc_op_d_s      = 1'b0;
        if (alu_op_d_s) begin
            flag_write_d_s = {InstrD[4], InstrD[4] & (InstrD[7:5] != CMD_MOV)};
            case (InstrD[7:5])
                CMD_ADD: alu_ctrl_d_s = ALUCTRL_W'(CMD_ADD);
                CMD_SUB: alu_ctrl_d_s = ALUCTRL_W'(CMD_SUB);
                CMD_MUL: alu_ctrl_d_s = ALUCTRL_W'(CMD_MUL);
                CMD_DIV: begin
                    alu_ctrl_d_s = ALUCTRL_W'(CMD_DIV);
                    mc_op_d_s    = 1'b1;
                end
                CMD_MOD: begin
                    alu_ctrl_d_s = ALUCTRL_W'(CMD_MOD);
                    mc_op_d_s    = 1'b1;
                end
                CMD_MOV: alu_ctrl_d_s = ALUCTRL_W'(CMD_MOV);
                CMD_EQV: begin
                    // compare-only: subtract for the flags, never write Rd
                    alu_ctrl_d_s = ALUCTRL_W'(CMD_SUB);
                    no_write_d_s = 1'b1;
                end
                default: alu_ctrl_d_s = ALUCTRL_W'(CMD_ADD);
            endcase
        end else begin
            alu_ctrl_d_s   = ALUCTRL_W'(CMD_ADD);
            flag_write_d_s = 2'b00;
        end
    end

    assign pc_src_d_s = ((InstrD[3:0] == PC_IDX) & reg_write_d_s & ~no_write_d_s) | branch_d_s;

    // E-stage evaluation: condition, commit qualifier and flag-write mask
    assign cond_ex_e_s = ~cond_e_r | flags_e_r[Z_IDX];
    assign commit_e_s  = cond_ex_e_s & ~mc_busy_s;
    assign flag_upd_s  = cond_ex_e_s & (|flag_write_e_r) & ~mc_busy_s;
    assign flag_mask_s = {{(FLAG_W/2){flag_write_e_r[1]}}, {(FLAG_W - FLAG_W/2){flag_write_e_r[0]}}};
    assign mc_trig_s   = mc_op_e_r & (reg_write_e_r | (|flag_write_e_r)) & ~FlushE;

    // Sequencer next state: start pulse, busy window, one DONE cycle to commit
    always_comb begin
        state_n_s  = state_r;
        cnt_n_s    = cnt_r;
        mc_start_s = 1'b0;
        mc_busy_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mc_trig_s) begin
                    mc_start_s = 1'b1;
                    mc_busy_s  = 1'b1;
                    cnt_n_s    = 8'(DIV_CYCLES - 2);
                    state_n_s  = (DIV_CYCLES > 2) ? ST_BUSY : ST_DONE;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                mc_busy_s = 1'b1;
                cnt_n_s   = cnt_r - 8'd1;
                // leave once the decremented count reaches zero
                if (cnt_r <= 8'd1) begin
                    state_n_s = ST_DONE;
                end else begin
                    state_n_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_n_s = ST_IDLE;
            end
            default: begin
                state_n_s = ST_IDLE;
                cnt_n_s   = 8'd0;
            end
        endcase
        if (FlushE) begin
            state_n_s = ST_IDLE;
            cnt_n_s   = 8'd0;
        end else begin
            state_n_s = state_n_s;
        end
    end

    // Sequencer state and counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    // E-stage control registers: flush clears, multi-cycle busy holds
    always_ff @(posedge clk) begin
        if (!reset || FlushE) begin
            alu_src_e_r    <= 1'b0;
            alu_ctrl_e_r   <= '0;
            mem_to_reg_e_r <= 1'b0;
            reg_write_e_r  <= 1'b0;
            mem_write_e_r  <= 1'b0;
            branch_e_r     <= 1'b0;
            pc_src_e_r     <= 1'b0;
            flag_write_e_r <= 2'b00;
            cond_e_r       <= 1'b0;
            no_write_e_r   <= 1'b0;
            mc_op_e_r      <= 1'b0;
        end else if (!mc_busy_s) begin
            alu_src_e_r    <= alu_src_d_s;
            alu_ctrl_e_r   <= alu_ctrl_d_s;
            mem_to_reg_e_r <= mem_to_reg_d_s;
            reg_write_e_r  <= reg_write_d_s;
            mem_write_e_r  <= mem_write_d_s;
            branch_e_r     <= branch_d_s;
            pc_src_e_r     <= pc_src_d_s;
            flag_write_e_r <= flag_write_d_s;
            cond_e_r       <= InstrD[11];
            no_write_e_r   <= no_write_d_s;
            mc_op_e_r      <= mc_op_d_s;
        end
    end

    // Condition flags: masked update from the ALU when the E instruction commits
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_e_r <= '0;
        end else if (flag_upd_s) begin
            flags_e_r <= (flags_e_r & ~flag_mask_s) | (ALUFlagsE & flag_mask_s);
        end
    end

    // M and W pipeline registers; M takes a bubble while the sequencer is busy
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_to_reg_m_r <= 1'b0;
            reg_write_m_r  <= 1'b0;
            mem_write_m_r  <= 1'b0;
            pc_src_m_r     <= 1'b0;
            mem_to_reg_w_r <= 1'b0;
            reg_write_w_r  <= 1'b0;
            pc_src_w_r     <= 1'b0;
        end else begin
            mem_to_reg_m_r <= mem_to_reg_e_r & ~mc_busy_s;
            reg_write_m_r  <= reg_write_e_r & ~no_write_e_r & commit_e_s;
            mem_write_m_r  <= mem_write_e_r & commit_e_s;
            pc_src_m_r     <= pc_src_e_r & commit_e_s;
            mem_to_reg_w_r <= mem_to_reg_m_r;
            reg_write_w_r  <= reg_write_m_r;
            pc_src_w_r     <= pc_src_m_r;
        end
    end

    // D-stage outputs are forced quiet while reset is held
    assign RegSrcD      = reset ? reg_src_d_s : 2'b00;
    assign ImmSrcD      = reset ? imm_src_d_s : 2'b00;
    assign ALUSrcE      = alu_src_e_r;
    assign ALUControlE  = alu_ctrl_e_r;
    assign BranchTakenE = branch_e_r & cond_ex_e_s;
    assign MCStartE     = mc_start_s;
    assign MCBusy       = mc_busy_s;
    assign MemtoRegE    = mem_to_reg_e_r;
    assign MemWriteM    = mem_write_m_r;
    assign RegWriteM    = reg_write_m_r;
    assign MemtoRegW    = mem_to_reg_w_r;
    assign RegWriteW    = reg_write_w_r;
    assign PCSrcW       = pc_src_w_r;
    assign PCWrPendingF = (pc_src_d_s & reset) | pc_src_e_r | pc_src_m_r;

endmodule

// File: tb/tb_pipe_controller_mc.sv
// Directed bench for pipe_controller_mc with hand-computed expectations.
module tb_pipe_controller_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] InstrD;
    logic [3:0]  ALUFlagsE;
    logic        FlushE;
    logic [1:0]  RegSrcD;
    logic [1:0]  ImmSrcD;
    logic        ALUSrcE;
    logic [2:0]  ALUControlE;
    logic        BranchTakenE;
    logic        MCStartE;
    logic        MCBusy;
    logic        MemtoRegE;
    logic        MemWriteM;
    logic        RegWriteM;
    logic        MemtoRegW;
    logic        RegWriteW;
    logic        PCSrcW;
    logic        PCWrPendingF;

    int n_vec = 0;
    int n_err = 0;

    pipe_controller_mc dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE), .FlushE(FlushE),
        .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .BranchTakenE(BranchTakenE), .MCStartE(MCStartE), .MCBusy(MCBusy),
        .MemtoRegE(MemtoRegE), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
        .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW), .PCSrcW(PCSrcW),
        .PCWrPendingF(PCWrPendingF)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] enc(input logic c, input logic [1:0] op, input logic b22,
                                        input logic [2:0] cmd, input logic b18, input logic [3:0] rd);
        return {c, op, b22, cmd, b18, rd};
    endfunction

    logic [11:0] nop_i, add_s_i, eqv_i, cadd_i, div_i, mod_i, br_i, put_i, get_i, mulpc_i;

    initial begin
        nop_i   = enc(1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 4'd0);
        add_s_i = enc(1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 4'd1);
        eqv_i   = enc(1'b0, 2'b00, 1'b0, 3'b110, 1'b1, 4'd2);
        cadd_i  = enc(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 4'd1);
        div_i   = enc(1'b0, 2'b00, 1'b0, 3'b011, 1'b0, 4'd3);
        mod_i   = enc(1'b0, 2'b00, 1'b0, 3'b100, 1'b0, 4'd3);
        br_i    = enc(1'b1, 2'b01, 1'b0, 3'b000, 1'b0, 4'd0);
        put_i   = enc(1'b0, 2'b10, 1'b0, 3'b000, 1'b0, 4'd5);
        get_i   = enc(1'b0, 2'b10, 1'b0, 3'b000, 1'b1, 4'd4);
        mulpc_i = enc(1'b0, 2'b00, 1'b1, 3'b010, 1'b0, 4'b1001);

        // 1. reset held two cycles with random instructions
        reset = 1'b0; FlushE = 1'b0; ALUFlagsE = 4'h0; InstrD = 12'($urandom);
        tick;
        InstrD = 12'($urandom);
        tick;
        check_eq("rst_outs", 32'({RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MCStartE,
                                  MemtoRegE, MemWriteM, RegWriteM, MemtoRegW, RegWriteW, PCSrcW,
                                  PCWrPendingF}), 32'd0);
        check_eq("rst_busy", 32'(MCBusy), 32'd0);
        reset = 1'b1; InstrD = nop_i;
        tick; tick; tick;

        // memory decode: PUT then GET
        InstrD = put_i; #1;
        check_eq("put_regsrc", 32'(RegSrcD), 32'd2);
        check_eq("put_immsrc", 32'(ImmSrcD), 32'd1);
        tick;
        check_eq("put_alusrc_e", 32'(ALUSrcE), 32'd1);
        InstrD = get_i; #1;
        check_eq("get_regsrc", 32'(RegSrcD), 32'd0);
        tick;
        check_eq("put_memwr_m", 32'(MemWriteM), 32'd1);
        check_eq("put_regwr_m", 32'(RegWriteM), 32'd0);
        check_eq("get_mtr_e", 32'(MemtoRegE), 32'd1);
        InstrD = nop_i;
        tick;
        check_eq("get_regwr_m", 32'(RegWriteM), 32'd1);
        check_eq("get_memwr_m", 32'(MemWriteM), 32'd0);
        tick;
        check_eq("get_regwr_w", 32'(RegWriteW), 32'd1);
        check_eq("get_mtr_w", 32'(MemtoRegW), 32'd1);

        // data op with immediate writing the PC
        InstrD = mulpc_i; #1;
        check_eq("mulpc_pend_d", 32'(PCWrPendingF), 32'd1);
        tick;
        check_eq("mulpc_alusrc", 32'(ALUSrcE), 32'd1);
        check_eq("mulpc_aluctl", 32'(ALUControlE), 32'd2);
        InstrD = nop_i;
        tick; tick;
        check_eq("mulpc_pcsrc_w", 32'(PCSrcW), 32'd1);
        tick;

        // 2. ADD with S, then EQV (compare only)
        InstrD = add_s_i; ALUFlagsE = 4'b0000;
        tick;
        check_eq("add_aluctl", 32'(ALUControlE), 32'd0);
        InstrD = eqv_i;
        tick;
        check_eq("add_regwr_m", 32'(RegWriteM), 32'd1);
        check_eq("eqv_aluctl", 32'(ALUControlE), 32'd1);
        InstrD = nop_i; ALUFlagsE = 4'b0100;
        tick;
        check_eq("add_wb_3cyc", 32'(RegWriteW), 32'd1);
        check_eq("eqv_regwr_m", 32'(RegWriteM), 32'd0);
        InstrD = cadd_i; ALUFlagsE = 4'b0000;
        tick;
        check_eq("eqv_no_wb", 32'(RegWriteW), 32'd0);
        InstrD = nop_i;
        tick;
        check_eq("cond_z1_regwr_m", 32'(RegWriteM), 32'd1);
        tick;
        check_eq("cond_z1_regwr_w", 32'(RegWriteW), 32'd1);
        tick;

        // 3. DIV: 1-cycle start, 7 busy cycles, single commit 8 cycles after E entry
        InstrD = div_i;
        tick;
        InstrD = nop_i;
        check_eq("div_aluctl", 32'(ALUControlE), 32'd3);
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("div_start_%0d", i), 32'(MCStartE), 32'(i == 0));
            check_eq($sformatf("div_busy_%0d", i), 32'(MCBusy), 32'(i < 7));
            check_eq($sformatf("div_regwr_m_%0d", i), 32'(RegWriteM), 32'(i == 8));
            check_eq($sformatf("div_regwr_w_%0d", i), 32'(RegWriteW), 32'(i == 9));
            tick;
        end

        // 4. MOD flushed in BUSY with cnt=3
        InstrD = mod_i;
        tick;
        InstrD = nop_i;
        check_eq("mod_aluctl", 32'(ALUControlE), 32'd4);
        tick; tick; tick; tick;
        check_eq("mod_busy_cnt3", 32'(MCBusy), 32'd1);
        FlushE = 1'b1;
        tick;
        FlushE = 1'b0;
        check_eq("flush_busy", 32'(MCBusy), 32'd0);
        check_eq("flush_start", 32'(MCStartE), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("flush_no_wr_%0d", i), 32'({RegWriteM, RegWriteW}), 32'd0);
            tick;
        end

        // 5a. conditional branch with Z=0: not taken
        InstrD = add_s_i;
        tick;
        ALUFlagsE = 4'b0000; InstrD = br_i; #1;
        check_eq("br_regsrc", 32'(RegSrcD), 32'd1);
        check_eq("br_immsrc", 32'(ImmSrcD), 32'd2);
        check_eq("brn_pend_d", 32'(PCWrPendingF), 32'd1);
        tick;
        InstrD = nop_i;
        check_eq("brn_taken", 32'(BranchTakenE), 32'd0);
        check_eq("brn_pend_e", 32'(PCWrPendingF), 32'd1);
        tick;
        check_eq("brn_pend_m", 32'(PCWrPendingF), 32'd0);
        tick;
        check_eq("brn_pcsrc_w", 32'(PCSrcW), 32'd0);

        // 5b. conditional branch with Z=1: taken, pending for 3 cycles
        InstrD = eqv_i;
        tick;
        ALUFlagsE = 4'b0100; InstrD = br_i; #1;
        check_eq("brt_pend_d", 32'(PCWrPendingF), 32'd1);
        tick;
        ALUFlagsE = 4'b0000; InstrD = nop_i;
        check_eq("brt_taken", 32'(BranchTakenE), 32'd1);
        check_eq("brt_pend_e", 32'(PCWrPendingF), 32'd1);
        tick;
        check_eq("brt_pend_m", 32'(PCWrPendingF), 32'd1);
        tick;
        check_eq("brt_pend_w", 32'(PCWrPendingF), 32'd0);
        check_eq("brt_pcsrc_w", 32'(PCSrcW), 32'd1);
        tick;

        // 6. reset during BUSY: divide never commits
        InstrD = div_i;
        tick;
        InstrD = nop_i;
        tick; tick; tick;
        check_eq("rstbusy_busy_pre", 32'(MCBusy), 32'd1);
        reset = 1'b0;
        tick;
        check_eq("rstbusy_busy", 32'(MCBusy), 32'd0);
        check_eq("rstbusy_start", 32'(MCStartE), 32'd0);
        check_eq("rstbusy_aluctl", 32'(ALUControlE), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("rstbusy_no_wr_%0d", i), 32'({RegWriteM, RegWriteW, MCBusy}), 32'd0);
            tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
